// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the hardwired sequencer.
// Holds opcode values, register-file/ARF function codes, ALU operation codes,
// datapath mux select codes, register enable patterns, the sequencer state
// enum, the decoded operation class enum and the register one-hot helper.
package cpu_ctrl_pkg;

    // Instruction opcodes, IROut[15:12]
    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;
    localparam logic [3:0] OP_BRA = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Register / IR function select codes
    localparam logic [1:0] FUN_DEC   = 2'b00;
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [1:0] FUN_LOAD  = 2'b10;
    localparam logic [1:0] FUN_CLEAR = 2'b11;

    // ALU operation codes
    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b0001;
    localparam logic [3:0] ALU_NOT_A  = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_XOR    = 4'b1001;

    // MuxA / MuxB select codes
    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    // MuxC select: RF OutA feeds ALU operand A
    localparam logic       MUXC_RFA = 1'b0;

    // ARF output selects
    localparam logic [1:0] ARF_SEL_AR = 2'b00;
    localparam logic [1:0] ARF_SEL_PC = 2'b10;

    // ARF write enables: bit2=AR, bit1=SP, bit0=PC
    localparam logic [3:0] ARF_EN_NONE = 4'b0000;
    localparam logic [3:0] ARF_EN_PC   = 4'b0001;
    localparam logic [3:0] ARF_EN_AR   = 4'b0100;
    localparam logic [3:0] ARF_EN_ALL  = 4'b0111;

    // RF write enables: bit3=R1 ... bit0=R4
    localparam logic [3:0] RF_EN_NONE = 4'b0000;
    localparam logic [3:0] RF_EN_ALL  = 4'b1111;

    // Sequencer states; the encoding doubles as the SeqCount debug value
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_INIT = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    // Decoded operation classes
    typedef enum logic [3:0] {
        CLS_LDI = 4'd0,
        CLS_LD  = 4'd1,
        CLS_ST  = 4'd2,
        CLS_MOV = 4'd3,
        CLS_ALU = 4'd4,
        CLS_INC = 4'd5,
        CLS_DEC = 4'd6,
        CLS_BRA = 4'd7,
        CLS_BEQ = 4'd8,
        CLS_BNE = 4'd9,
        CLS_HLT = 4'd10
    } op_class_e;

    // Register number (00=R1 .. 11=R4) to RF write-enable one-hot (R1 is bit3)
    function automatic logic [3:0] rf_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            2'b00:   oh = 4'b1000;
            2'b01:   oh = 4'b0100;
            2'b10:   oh = 4'b0010;
            2'b11:   oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational instruction decoder.
// Ports:
//   IROut    in  16  instruction register contents
//   opClass  out  4  operation class (op_class_e encoding)
//   aluFun   out  4  ALU operation for register-to-register classes
//   rdOneHot out  4  RF write enable for the destination register
//   writesZ  out  1  instruction result updates the latched Z flag
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] IROut,
    output logic [3:0]  opClass,
    output logic [3:0]  aluFun,
    output logic [3:0]  rdOneHot,
    output logic        writesZ
);

    // Rs and the immediate are routed by the datapath, not consumed here
    logic unused_fields_s;
    assign unused_fields_s = ^IROut[9:0];

    assign rdOneHot = rf_onehot(IROut[11:10]);

    // Opcode to class, ALU operation and flag-update map
    always_comb begin
        opClass = CLS_HLT;
        aluFun  = ALU_PASS_A;
        writesZ = 1'b0;
        case (IROut[15:12])
            OP_LDI: opClass = CLS_LDI;
            OP_LD:  opClass = CLS_LD;
            OP_ST:  opClass = CLS_ST;
            OP_MOV: begin opClass = CLS_MOV; aluFun = ALU_PASS_B; end
            OP_ADD: begin opClass = CLS_ALU; aluFun = ALU_ADD;   writesZ = 1'b1; end
            OP_SUB: begin opClass = CLS_ALU; aluFun = ALU_SUB;   writesZ = 1'b1; end
            OP_AND: begin opClass = CLS_ALU; aluFun = ALU_AND;   writesZ = 1'b1; end
            OP_OR:  begin opClass = CLS_ALU; aluFun = ALU_OR;    writesZ = 1'b1; end
            OP_XOR: begin opClass = CLS_ALU; aluFun = ALU_XOR;   writesZ = 1'b1; end
            OP_NOT: begin opClass = CLS_ALU; aluFun = ALU_NOT_A; writesZ = 1'b1; end
            OP_INC: opClass = CLS_INC;
            OP_DEC: opClass = CLS_DEC;
            OP_BRA: opClass = CLS_BRA;
            OP_BEQ: opClass = CLS_BEQ;
            OP_BNE: opClass = CLS_BNE;
            OP_HLT: opClass = CLS_HLT;
            default: opClass = CLS_HLT;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for the 8-bit ALU/register-file datapath.
// Fetches a 16-bit instruction as two bytes (low byte first) into IR, decodes
// it, executes in one (or two, for LD/ST) cycles and returns to fetch.
// Ports:
//   Clock, Reset (sync, active-high)   IROut (instruction)   ALUOutFlag {Z,C,N,O}
//   RF_*  : register-file read selects, function, write enables
//   ALU_FunSel : ALU operation
//   ARF_* : address-register-file selects, function, write enables
//   IR_*  : instruction-register half select, enable, function
//   Mem_WR / Mem_CS (active-low) : memory control
//   MuxASel, MuxBSel, MuxCSel : datapath source selects
//   Halted : high in HALT;  SeqCount : current T-state for debug
// Control outputs are decoded from the registered state; they cannot be
// registered one cycle ahead because IROut only holds the complete
// instruction from T2 onward.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int FLAG_Z_BIT = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [2:0]  SeqCount
);

    state_e     state_r;
    state_e     next_state_s;
    logic       z_latch_r;
    logic       halted_r;
    logic [3:0] op_class_s;
    logic [3:0] alu_fun_s;
    logic [3:0] rd_onehot_s;
    logic       writes_z_s;
    logic       take_branch_s;
    logic [1:0] rd_s;
    logic [1:0] rs_s;

    // Only the Z bit is consumed; the other flags belong to the datapath
    logic unused_flags_s;
    assign unused_flags_s = ^ALUOutFlag;

    assign rd_s = IROut[11:10];
    assign rs_s = IROut[9:8];

    instr_decode u_decode (
        .IROut    (IROut),
        .opClass  (op_class_s),
        .aluFun   (alu_fun_s),
        .rdOneHot (rd_onehot_s),
        .writesZ  (writes_z_s)
    );

    // Branch condition evaluated against the Z flag latched by an earlier ALU op
    always_comb begin
        take_branch_s = 1'b0;
        case (op_class_s)
            CLS_BRA: take_branch_s = 1'b1;
            CLS_BEQ: take_branch_s = z_latch_r;
            CLS_BNE: take_branch_s = ~z_latch_r;
            default: take_branch_s = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: next_state_s = ST_T0;
            ST_T0:   next_state_s = ST_T1;
            ST_T1:   next_state_s = ST_T2;
            ST_T2: begin
                if ((op_class_s == CLS_LD) || (op_class_s == CLS_ST)) begin
                    next_state_s = ST_T3;
                end else if (op_class_s == CLS_HLT) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_T0;
                end
            end
            ST_T3:   next_state_s = ST_T0;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_INIT;
        endcase
    end

    // Sequencer state, latched Z flag and registered Halted
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= ST_INIT;
            z_latch_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == ST_HALT);
            if ((state_r == ST_T2) && writes_z_s) begin
                z_latch_r <= ALUOutFlag[FLAG_Z_BIT];
            end
        end
    end

    assign Halted   = halted_r;
    assign SeqCount = state_r;

    // Datapath control vector for the current state; idle unless overridden
    always_comb begin
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = FUN_DEC;
        RF_RSel     = RF_EN_NONE;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = ALU_PASS_A;
        ARF_OutCSel = ARF_SEL_AR;
        ARF_OutDSel = ARF_SEL_AR;
        ARF_FunSel  = FUN_DEC;
        ARF_RegSel  = ARF_EN_NONE;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = FUN_DEC;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = MUX_ALU;
        MuxBSel     = MUX_ALU;
        MuxCSel     = MUXC_RFA;
        if (Reset) begin
            // Reset forces the idle vector, killing any in-flight memory write
            Mem_WR = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    RF_RSel    = RF_EN_ALL;
                    RF_FunSel  = FUN_CLEAR;
                    ARF_RegSel = ARF_EN_ALL;
                    ARF_FunSel = FUN_CLEAR;
                end
                ST_T0, ST_T1: begin
                    // Read byte at PC into the selected IR half, then bump PC
                    ARF_OutDSel = ARF_SEL_PC;
                    Mem_CS      = 1'b0;
                    IR_Enable   = 1'b1;
                    IR_LH       = (state_r == ST_T1);
                    IR_Funsel   = FUN_LOAD;
                    ARF_RegSel  = ARF_EN_PC;
                    ARF_FunSel  = FUN_INC;
                end
                ST_T2: begin
                    case (op_class_s)
                        CLS_LDI: begin
                            MuxASel   = MUX_IMM;
                            RF_RSel   = rd_onehot_s;
                            RF_FunSel = FUN_LOAD;
                        end
                        CLS_LD, CLS_ST: begin
                            // Stage the memory address in AR for T3
                            MuxBSel    = MUX_IMM;
                            ARF_RegSel = ARF_EN_AR;
                            ARF_FunSel = FUN_LOAD;
                        end
                        CLS_MOV: begin
                            RF_OutBSel = rs_s;
                            ALU_FunSel = alu_fun_s;
                            MuxASel    = MUX_ALU;
                            RF_RSel    = rd_onehot_s;
                            RF_FunSel  = FUN_LOAD;
                        end
                        CLS_ALU: begin
                            RF_OutASel = rd_s;
                            RF_OutBSel = rs_s;
                            MuxCSel    = MUXC_RFA;
                            ALU_FunSel = alu_fun_s;
                            MuxASel    = MUX_ALU;
                            RF_RSel    = rd_onehot_s;
                            RF_FunSel  = FUN_LOAD;
                        end
                        CLS_INC: begin
                            RF_RSel   = rd_onehot_s;
                            RF_FunSel = FUN_INC;
                        end
                        CLS_DEC: begin
                            RF_RSel   = rd_onehot_s;
                            RF_FunSel = FUN_DEC;
                        end
                        CLS_BRA, CLS_BEQ, CLS_BNE: begin
                            if (take_branch_s) begin
                                MuxBSel    = MUX_IMM;
                                ARF_RegSel = ARF_EN_PC;
                                ARF_FunSel = FUN_LOAD;
                            end else begin
                                ARF_RegSel = ARF_EN_NONE;
                            end
                        end
                        default: begin
                            // HLT and anything unmapped drive nothing
                            ARF_RegSel = ARF_EN_NONE;
                        end
                    endcase
                end
                ST_T3: begin
                    ARF_OutDSel = ARF_SEL_AR;
                    Mem_CS      = 1'b0;
                    if (op_class_s == CLS_LD) begin
                        MuxASel   = MUX_MEM;
                        RF_RSel   = rd_onehot_s;
                        RF_FunSel = FUN_LOAD;
                        Mem_WR    = 1'b0;
                    end else if (op_class_s == CLS_ST) begin
                        // Rd passes through the ALU onto the memory data bus
                        RF_OutASel = rd_s;
                        MuxCSel    = MUXC_RFA;
                        ALU_FunSel = ALU_PASS_A;
                        Mem_WR     = 1'b1;
                    end else begin
                        Mem_WR = 1'b0;
                    end
                end
                default: begin
                    // INIT-less idle for HALT and illegal encodings
                    Mem_CS = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle pushes the full
// expected control vector; the negedge monitor pops and compares it.
module tb_control_unit;

    localparam logic [2:0] SEQ_T2   = 3'd2;
    localparam logic [2:0] SEQ_T3   = 3'd3;
    localparam logic [2:0] SEQ_INIT = 3'd4;
    localparam logic [2:0] SEQ_HALT = 3'd5;

    typedef struct packed {
        logic [1:0] outA;
        logic [1:0] outB;
        logic [1:0] rfFun;
        logic [3:0] rSel;
        logic [3:0] tSel;
        logic [3:0] aluFun;
        logic [1:0] outC;
        logic [1:0] outD;
        logic [1:0] arfFun;
        logic [3:0] arfReg;
        logic       irLh;
        logic       irEn;
        logic [1:0] irFun;
        logic       memWr;
        logic       memCs;
        logic [1:0] muxA;
        logic [1:0] muxB;
        logic       muxC;
        logic       halted;
        logic [2:0] seq;
    } ctrl_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;
    logic [2:0]  SeqCount;

    ctrl_t obs_s;
    ctrl_t exp_q[$];
    string tag_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    control_unit #(.FLAG_Z_BIT(3)) dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .Halted(Halted), .SeqCount(SeqCount)
    );

    assign obs_s = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                    ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable,
                    IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted, SeqCount};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pops one expectation per cycle, sampled away from the rising edge
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), 64'(obs_s), 64'(exp_q.pop_front()));
        end
    end

    function automatic ctrl_t idle_v(input logic [2:0] seq, input logic halted);
        ctrl_t v;
        v = '0;
        v.memCs  = 1'b1;
        v.seq    = seq;
        v.halted = halted;
        return v;
    endfunction

    function automatic ctrl_t init_v();
        ctrl_t v;
        v = idle_v(SEQ_INIT, 1'b0);
        v.rSel   = 4'b1111;
        v.rfFun  = 2'b11;
        v.arfReg = 4'b0111;
        v.arfFun = 2'b11;
        return v;
    endfunction

    function automatic ctrl_t fetch_v(input logic lh);
        ctrl_t v;
        v = idle_v({2'b00, lh}, 1'b0);
        v.outD   = 2'b10;
        v.memCs  = 1'b0;
        v.irEn   = 1'b1;
        v.irLh   = lh;
        v.irFun  = 2'b10;
        v.arfReg = 4'b0001;
        v.arfFun = 2'b01;
        return v;
    endfunction

    function automatic ctrl_t alu_v(input logic [1:0] a, input logic [1:0] b,
                                    input logic [3:0] fn, input logic [3:0] rsel);
        ctrl_t v;
        v = idle_v(SEQ_T2, 1'b0);
        v.outA   = a;
        v.outB   = b;
        v.aluFun = fn;
        v.rSel   = rsel;
        v.rfFun  = 2'b10;
        return v;
    endfunction

    function automatic ctrl_t imm_v(input logic [3:0] arfReg);
        ctrl_t v;
        v = idle_v(SEQ_T2, 1'b0);
        v.muxB   = 2'b10;
        v.arfReg = arfReg;
        v.arfFun = 2'b10;
        return v;
    endfunction

    task automatic step(input logic rst, input logic [15:0] ir, input logic [3:0] flg,
                        input ctrl_t exp, input string tag);
        @(posedge Clock);
        #1;
        Reset      = rst;
        IROut      = ir;
        ALUOutFlag = flg;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic do_instr(input logic [15:0] ir, input logic [3:0] flg,
                            input ctrl_t t2, input string tag);
        step(1'b0, ir, 4'b0000, fetch_v(1'b0), {tag, "_t0"});
        step(1'b0, ir, 4'b0000, fetch_v(1'b1), {tag, "_t1"});
        step(1'b0, ir, flg, t2, {tag, "_t2"});
    endtask

    ctrl_t tmp;

    initial begin
        Reset = 1'b1;
        IROut = 16'h0000;
        ALUOutFlag = 4'b0000;

        step(1'b1, 16'h0000, 4'b0000, idle_v(SEQ_INIT, 1'b0), "reset_idle");
        step(1'b0, 16'h0000, 4'b0000, init_v(), "init");

        do_instr(16'h4100, 4'b0000, alu_v(2'b00, 2'b01, 4'b0100, 4'b1000), "add");

        tmp = idle_v(SEQ_T2, 1'b0); tmp.muxA = 2'b10; tmp.rSel = 4'b0001; tmp.rfFun = 2'b10;
        do_instr(16'h0C7F, 4'b0000, tmp, "ldi");

        tmp = idle_v(SEQ_T2, 1'b0); tmp.outB = 2'b10; tmp.aluFun = 4'b0001;
        tmp.rSel = 4'b0100; tmp.rfFun = 2'b10;
        do_instr(16'h3600, 4'b0000, tmp, "mov");

        do_instr(16'h8E00, 4'b0000, alu_v(2'b11, 2'b10, 4'b1001, 4'b0001), "xor");

        do_instr(16'h1820, 4'b0000, imm_v(4'b0100), "ld");
        tmp = idle_v(SEQ_T3, 1'b0); tmp.memCs = 1'b0; tmp.muxA = 2'b01;
        tmp.rSel = 4'b0010; tmp.rfFun = 2'b10;
        step(1'b0, 16'h1820, 4'b0000, tmp, "ld_t3");

        do_instr(16'h2C30, 4'b0000, imm_v(4'b0100), "st");
        tmp = idle_v(SEQ_T3, 1'b0); tmp.memCs = 1'b0; tmp.outA = 2'b11; tmp.memWr = 1'b1;
        step(1'b0, 16'h2C30, 4'b0000, tmp, "st_t3");
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        step(1'b0, 16'h2C30, 4'b0000, init_v(), "st_reset_init");

        // Z set by SUB survives INC, so BEQ is taken
        do_instr(16'h5100, 4'b1000, alu_v(2'b00, 2'b01, 4'b0110, 4'b1000), "sub_z1");
        tmp = idle_v(SEQ_T2, 1'b0); tmp.rSel = 4'b0100; tmp.rfFun = 2'b01;
        do_instr(16'hA400, 4'b0000, tmp, "inc");
        do_instr(16'hD055, 4'b0000, imm_v(4'b0001), "beq_taken");

        do_instr(16'h5100, 4'b1000, alu_v(2'b00, 2'b01, 4'b0110, 4'b1000), "sub_z1b");
        do_instr(16'hE055, 4'b0000, idle_v(SEQ_T2, 1'b0), "bne_not_taken");

        do_instr(16'h5100, 4'b0000, alu_v(2'b00, 2'b01, 4'b0110, 4'b1000), "sub_z0");
        do_instr(16'hE055, 4'b0000, imm_v(4'b0001), "bne_taken");
        do_instr(16'hD055, 4'b0000, idle_v(SEQ_T2, 1'b0), "beq_not_taken");

        do_instr(16'hF000, 4'b0000, idle_v(SEQ_T2, 1'b0), "hlt");
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'($urandom()), 4'($urandom()), idle_v(SEQ_HALT, 1'b1), "halt_idle");
        end
        step(1'b1, 16'h0000, 4'b0000, idle_v(SEQ_HALT, 1'b1), "halt_reset");
        step(1'b0, 16'h0000, 4'b0000, init_v(), "halt_init");
        step(1'b0, 16'h0000, 4'b0000, fetch_v(1'b0), "after_halt_t0");

        @(negedge Clock);
        #1;
        check_eq("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
